// File: rtl/apb_mem_completer_pkg.sv
// Shared types and constants for the APB memory completer.
package apb_mem_completer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } apb_state_e;

   localparam logic APB_RESP_OKAY = 1'b0;
   localparam logic APB_RESP_ERR  = 1'b1;
   localparam int   WAIT_W        = 4;

endpackage

// File: rtl/apb_mem_array.sv
// Word memory with one synchronous write port and one combinational read port.
module apb_mem_array #(
   parameter int WORDS      = 256,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [IDX_W-1:0]      raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/apb_mem_completer.sv
// APB completer backed by a word memory window, with wait-state insertion and
// per-outcome transfer counters.
//
// state | meaning
// IDLE  | waiting for a new psel assertion; request fields latched on start
// SETUP | setup phase; waits for penable when strict gating is enabled
// WAIT  | counting inserted wait states; psel drop aborts
// DONE  | pready pulse; an accepted write lands in memory at the end of this cycle
module apb_mem_completer
   import apb_mem_completer_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    MEM_WORDS      = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int                    WAIT_STATES    = 2,
   parameter bit                    STRICT_PENABLE = 1'b0
) (
   input  logic                  pclk,
   input  logic                  preset,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   input  logic [3:0]            wait_cfg,
   input  logic                  wait_cfg_en,
   output logic                  pready,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pslverr,
   output logic [15:0]           wr_count,
   output logic [15:0]           rd_count,
   output logic [15:0]           err_count
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
   localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(4 * MEM_WORDS);

   apb_state_e            state_q;
   logic                  psel_d;
   logic                  wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [WAIT_W-1:0]     n_q;
   logic [WAIT_W-1:0]     cnt_q;

   logic                  start;
   logic                  setup_go;
   logic                  enter_done;
   logic                  addr_err;
   logic [ADDR_WIDTH:0]   addr_ext;
   logic [ADDR_WIDTH-1:0] offset;
   logic [IDX_W-1:0]      mem_idx;
   logic [WAIT_W-1:0]     n_next;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_rdata;

   always_comb begin
      addr_ext   = {1'b0, addr_q};
      offset     = addr_q - BASE_ADDR;
      mem_idx    = IDX_W'(offset >> 2);
      addr_err   = (addr_ext < WIN_LO) || (addr_ext >= WIN_HI) || (addr_q[1:0] != 2'b00);
      n_next     = wait_cfg_en ? wait_cfg : WAIT_W'(WAIT_STATES);
      start      = psel && (!psel_d || (STRICT_PENABLE && !penable));
      setup_go   = psel && (!STRICT_PENABLE || penable);
      enter_done = ((state_q == SETUP) && setup_go && (n_q == '0)) ||
                   ((state_q == WAIT) && psel && (cnt_q == WAIT_W'(1)));
      // pslverr is still high during DONE for a rejected transfer, which blocks the write.
      mem_we     = (state_q == DONE) && wr_q && !pslverr && !preset;
   end

   apb_mem_array #(
      .WORDS      (MEM_WORDS),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_mem (
      .clk   (pclk),
      .we    (mem_we),
      .waddr (mem_idx),
      .wdata (wdata_q),
      .raddr (mem_idx),
      .rdata (mem_rdata)
   );

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q   <= IDLE;
         psel_d    <= 1'b0;
         pready    <= 1'b0;
         pslverr   <= APB_RESP_OKAY;
         prdata    <= '0;
         wr_count  <= '0;
         rd_count  <= '0;
         err_count <= '0;
      end else begin
         psel_d  <= psel;
         pready  <= 1'b0;
         pslverr <= APB_RESP_OKAY;
         case (state_q)
            IDLE: begin
               if (start) begin
                  addr_q  <= paddr;
                  wdata_q <= pwdata;
                  wr_q    <= pwrite;
                  n_q     <= n_next;
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               if (!psel) begin
                  state_q <= IDLE;
               end else if (setup_go) begin
                  if (n_q != '0) begin
                     cnt_q   <= n_q;
                     state_q <= WAIT;
                  end else begin
                     state_q <= DONE;
                  end
               end
            end
            WAIT: begin
               if (!psel) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - WAIT_W'(1);
                  if (cnt_q == WAIT_W'(1)) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase

         if (enter_done) begin
            pready <= 1'b1;
            if (addr_err) begin
               pslverr   <= APB_RESP_ERR;
               prdata    <= '0;
               err_count <= err_count + 16'd1;
            end else if (wr_q) begin
               wr_count <= wr_count + 16'd1;
            end else begin
               prdata   <= mem_rdata;
               rd_count <= rd_count + 16'd1;
            end
         end
      end
   end

endmodule
